// File: rtl/fifo_ctrl_pkg.sv
// Shared constants for the FIFO controller that sits beside the 8x10 dual-port RAM.
package fifo_ctrl_pkg;

   localparam int DEPTH      = 8;
   localparam int AW         = 3;
   localparam int AF_DEFAULT = 6;
   localparam int AE_DEFAULT = 1;

endpackage : fifo_ctrl_pkg

// File: rtl/fifo_ctrl.sv
// FIFO pointer/occupancy controller: drives the RAM enables and addresses directly
// and reports occupancy, status flags and sticky overflow/underflow errors.
module fifo_ctrl
   import fifo_ctrl_pkg::*;
#(
   parameter int DEPTH = fifo_ctrl_pkg::DEPTH,
   parameter int AW    = fifo_ctrl_pkg::AW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic          cfg_load,
   input  logic [AW:0]   af_thresh_in,
   input  logic [AW:0]   ae_thresh_in,
   output logic          we_a,
   output logic [AW-1:0] addr_wa,
   output logic          re_a,
   output logic [AW-1:0] addr_ra,
   output logic          rd_valid,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty,
   output logic          almost_full,
   output logic          almost_empty,
   output logic          overflow_err,
   output logic          underflow_err
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_INIT = (AW+1)'(AF_DEFAULT);
   localparam logic [AW:0] AE_INIT = (AW+1)'(AE_DEFAULT);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count_q;
   logic [AW:0]   af_reg;
   logic [AW:0]   ae_reg;

   assign full         = (count_q == DEPTH_C);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= af_reg);
   assign almost_empty = (count_q <= ae_reg);

   // Enables are masked by reset so the RAM sees no access while state is being cleared.
   assign we_a    = !reset && push && !full;
   assign re_a    = !reset && pop  && !empty;
   assign addr_wa = wr_ptr;
   assign addr_ra = rd_ptr;
   assign count   = count_q;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values.
      if (reset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count_q       <= '0;
         rd_valid      <= 1'b0;
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
         af_reg        <= AF_INIT;
         ae_reg        <= AE_INIT;
      end else begin
         // Pointers are exactly AW bits wide, so DEPTH-1 -> 0 wrap is free.
         if (we_a) wr_ptr <= wr_ptr + 1'b1;
         if (re_a) rd_ptr <= rd_ptr + 1'b1;

         unique case ({we_a, re_a})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase

         rd_valid <= re_a;

         if (push && full) overflow_err  <= 1'b1;
         if (pop && empty) underflow_err <= 1'b1;

         // Thresholds only change while nothing is stored, so flags never glitch mid-stream.
         if (cfg_load && empty) begin
            af_reg <= af_thresh_in;
            ae_reg <= ae_thresh_in;
         end
      end
   end

endmodule : fifo_ctrl

// File: tb/tb_fifo_ctrl.sv
// Directed self-checking bench for fifo_ctrl with hand-computed expectations.
module tb_fifo_ctrl;

   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          push;
   logic          pop;
   logic          cfg_load;
   logic [AW:0]   af_thresh_in;
   logic [AW:0]   ae_thresh_in;
   logic          we_a;
   logic [AW-1:0] addr_wa;
   logic          re_a;
   logic [AW-1:0] addr_ra;
   logic          rd_valid;
   logic [AW:0]   count;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic          overflow_err;
   logic          underflow_err;

   int checks = 0;
   int errors = 0;

   fifo_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .push         (push),
      .pop          (pop),
      .cfg_load     (cfg_load),
      .af_thresh_in (af_thresh_in),
      .ae_thresh_in (ae_thresh_in),
      .we_a         (we_a),
      .addr_wa      (addr_wa),
      .re_a         (re_a),
      .addr_ra      (addr_ra),
      .rd_valid     (rd_valid),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow_err (overflow_err),
      .underflow_err(underflow_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Advance one edge and settle 1 ns after it, away from the next edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic load_cfg(input int af, input int ae);
      cfg_load     = 1'b1;
      af_thresh_in = (AW+1)'(af);
      ae_thresh_in = (AW+1)'(ae);
      step();
      cfg_load = 1'b0;
   endtask

   task automatic push_n(input int n);
      push = 1'b1;
      repeat (n) step();
      push = 1'b0;
   endtask

   task automatic pop_n(input int n);
      pop = 1'b1;
      repeat (n) step();
      pop = 1'b0;
   endtask

   initial begin
      reset = 1'b1; push = 1'b0; pop = 1'b0; cfg_load = 1'b0;
      af_thresh_in = '0; ae_thresh_in = '0;
      step();
      // Requests during reset must not reach the RAM.
      push = 1'b1; pop = 1'b1; #1;
      check("rst_we_a", we_a, 0);
      check("rst_re_a", re_a, 0);
      step();
      push = 1'b0; pop = 1'b0; reset = 1'b0; #1;
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_almost_empty", almost_empty, 1);
      check("rst_full", full, 0);
      check("rst_almost_full", almost_full, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_ovf", overflow_err, 0);
      check("rst_unf", underflow_err, 0);

      // Fill: addresses 0..7, almost_full from 6, full at 8.
      for (int i = 0; i < DEPTH; i++) begin
         push = 1'b1; #1;
         check($sformatf("fill_addr_wa%0d", i), addr_wa, i);
         check($sformatf("fill_we_a%0d", i), we_a, 1);
         step();
         check($sformatf("fill_count%0d", i), count, i + 1);
         check($sformatf("fill_af%0d", i), almost_full, (i + 1 >= 6) ? 1 : 0);
         check($sformatf("fill_full%0d", i), full, (i + 1 == DEPTH) ? 1 : 0);
      end
      push = 1'b0; #1;
      check("fill_addr_wrap", addr_wa, 0);

      // Full with push+pop: write rejected, read accepted, overflow sticks.
      push = 1'b1; pop = 1'b1; #1;
      check("ovf_we_a", we_a, 0);
      check("ovf_re_a", re_a, 1);
      check("ovf_addr_ra", addr_ra, 0);
      step();
      push = 1'b0; pop = 1'b0;
      check("ovf_count", count, 7);
      check("ovf_flag", overflow_err, 1);
      check("ovf_rd_valid", rd_valid, 1);
      check("ovf_full", full, 0);

      // Drain to 4 entries: wr_ptr=0, rd_ptr=4.
      pop_n(3);
      check("mid_count", count, 4);
      // Ten simultaneous push+pop cycles: count holds, pointers wrap.
      for (int k = 0; k < 10; k++) begin
         push = 1'b1; pop = 1'b1; #1;
         check($sformatf("pp_addr_wa%0d", k), addr_wa, k % DEPTH);
         check($sformatf("pp_addr_ra%0d", k), addr_ra, (4 + k) % DEPTH);
         step();
         check($sformatf("pp_count%0d", k), count, 4);
         check($sformatf("pp_rd_valid%0d", k), rd_valid, 1);
      end
      push = 1'b0; pop = 1'b0; #1;
      check("pp_wr_end", addr_wa, 2);
      check("pp_rd_end", addr_ra, 6);
      step();
      check("pp_rd_valid_drop", rd_valid, 0);
      check("ovf_sticky", overflow_err, 1);

      // Underflow on an empty FIFO.
      do_reset();
      pop = 1'b1; #1;
      check("unf_re_a", re_a, 0);
      step();
      pop = 1'b0;
      check("unf_rd_valid", rd_valid, 0);
      check("unf_flag", underflow_err, 1);
      check("unf_count", count, 0);
      push_n(2);
      check("unf_sticky", underflow_err, 1);
      do_reset();
      check("unf_cleared", underflow_err, 0);

      // Threshold load while empty, then ignored while not empty.
      load_cfg(3, 0);
      check("cfg_ae_at0", almost_empty, 1);
      check("cfg_af_at0", almost_full, 0);
      push_n(1);
      check("cfg_ae_at1", almost_empty, 0);
      push_n(1);
      check("cfg_af_at2", almost_full, 0);
      push_n(1);
      check("cfg_af_at3", almost_full, 1);
      pop_n(2);
      check("cfg_count1", count, 1);
      load_cfg(1, 5);
      check("cfg_ign_af", almost_full, 0);
      check("cfg_ign_ae", almost_empty, 0);

      // Threshold above DEPTH: almost_full never asserts.
      do_reset();
      load_cfg(9, 1);
      push_n(DEPTH);
      check("big_af_full", full, 1);
      check("big_af_flag", almost_full, 0);

      // Reset mid-operation restores defaults and discards entries.
      do_reset();
      load_cfg(2, 4);
      push_n(5);
      check("mid_rst_count5", count, 5);
      check("mid_rst_af5", almost_full, 1);
      push = 1'b1; pop = 1'b1;
      check("mid_rst_overlay", we_a, 1);
      reset = 1'b1; #1;
      check("mid_rst_we_a", we_a, 0);
      step();
      reset = 1'b0; push = 1'b0; pop = 1'b0; #1;
      check("mid_rst_count", count, 0);
      check("mid_rst_empty", empty, 1);
      check("mid_rst_addr_wa", addr_wa, 0);
      check("mid_rst_ovf", overflow_err, 0);
      check("mid_rst_unf", underflow_err, 0);
      push_n(2);
      check("mid_rst_ae_def", almost_empty, 0);
      check("mid_rst_af_def2", almost_full, 0);
      push_n(3);
      check("mid_rst_af_def5", almost_full, 0);
      push_n(1);
      check("mid_rst_af_def6", almost_full, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_fifo_ctrl

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, number of RAM entries (power of two).
REQ-002 Parameter AW, default 3, address width, log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 push  input  1  write request; data is presented to the RAM data port by the upstream source in the same cycle.
REQ-006 pop  input  1  read request.
REQ-007 cfg_load  input  1  load new thresholds.
REQ-008 af_thresh_in  input  AW+1  almost-full threshold to load.
REQ-009 ae_thresh_in  input  AW+1  almost-empty threshold to load.
REQ-010 we_a  output  1  RAM write enable.
REQ-011 addr_wa  output  AW  RAM write address.
REQ-012 re_a  output  1  RAM read enable.
REQ-013 addr_ra  output  AW  RAM read address.
REQ-014 rd_valid  output  1  RAM read data valid; aligned with the RAM registered output.
REQ-015 count  output  AW+1  current occupancy, 0..DEPTH.
REQ-016 full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-017 overflow_err, underflow_err  output  1 each  sticky error flags.

Function
REQ-018 Write pointer wr_ptr and read pointer rd_ptr SHALL be AW-bit registers that wrap from DEPTH-1 to 0.
REQ-019 Occupancy count SHALL be an (AW+1)-bit register.
REQ-020 we_a SHALL be combinational: push && !full.
REQ-021 re_a SHALL be combinational: pop && !empty.
REQ-022 addr_wa SHALL equal wr_ptr and addr_ra SHALL equal rd_ptr, both combinational.
REQ-023 On each accepted write (we_a=1), wr_ptr SHALL increment at the clock edge.
REQ-024 On each accepted read (re_a=1), rd_ptr SHALL increment at the clock edge.
REQ-025 count SHALL update per edge: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-026 A push while full SHALL be rejected even with a simultaneous pop; a pop while empty SHALL be rejected even with a simultaneous push.
REQ-027 Simultaneous accepted push and pop SHALL leave count unchanged and advance both pointers.
REQ-028 rd_valid SHALL be re_a registered by one cycle, so that read data latency is 1 cycle.
REQ-029 Flags SHALL be combinational from registered state: full = (count==DEPTH), empty = (count==0), almost_full = (count>=af_reg), almost_empty = (count<=ae_reg).
REQ-030 overflow_err SHALL set on the edge after push && full and SHALL hold until reset.
REQ-031 underflow_err SHALL set on the edge after pop && empty and SHALL hold until reset.
REQ-032 When cfg_load=1 and empty=1, af_reg and ae_reg SHALL load af_thresh_in and ae_thresh_in at the edge.
REQ-033 cfg_load while not empty SHALL be ignored.
REQ-034 Threshold values above DEPTH SHALL be loaded unmodified (almost_full then never asserts).

Reset
REQ-035 While reset=1 at an edge, the following SHALL clear to 0: wr_ptr, rd_ptr, count, rd_valid, overflow_err, underflow_err.
REQ-036 While reset=1 at an edge, af_reg SHALL take DEPTH-2 (6) and ae_reg SHALL take 1.
REQ-037 While reset=1, we_a and re_a SHALL be forced to 0, and push, pop and cfg_load SHALL be ignored.
REQ-038 Reset asserted mid-operation SHALL discard all stored entries logically; RAM contents are not cleared.
REQ-039 After reset: empty=1, almost_empty=1, full=0, almost_full=0.

Structure
REQ-040 The shared package SHALL hold the constants DEPTH, AW, AF_DEFAULT=6 and AE_DEFAULT=1.
REQ-041 The block SHALL have no sub-module; it is instantiated alongside the 8x10 dual-port RAM, driving its address and enable ports directly.

Verification
REQ-042 Reset, then 8 pushes -> count=8, full=1, almost_full from count 6, addr_wa sequence 0..7 and back to 0.
REQ-043 Full FIFO, push=1 with pop=1 -> we_a=0, re_a=1, count=7, overflow_err=1 on the next cycle.
REQ-044 Count=4, push and pop for 10 cycles -> count stays 4, pointers wrap, rd_valid=1 each cycle after the first.
REQ-045 Empty FIFO, pop=1 -> re_a=0, rd_valid=0, underflow_err=1; the flag persists until reset.
REQ-046 Empty FIFO, cfg_load with af=3 and ae=0 -> after 3 pushes almost_full=1; with count=1, a further cfg_load is ignored.
REQ-047 Reset asserted at count=5 -> next cycle count=0, empty=1, errors cleared, thresholds at 6 and 1.
